// File: rtl/ram_burst_reader.sv
// Burst read initiator for the parallel-read lattice RAM: sweeps a word range on a start pulse
// and streams R-word beats on a valid/ready bus, absorbing the RAM's one-cycle read latency.
module ram_burst_reader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int RAMS_TO_ACCESS = 4,
  parameter int DEPTH          = 2500,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ADDRESS_WIDTH-1:0]             start_addr,
  input  logic [ADDRESS_WIDTH:0]               word_count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [ADDRESS_WIDTH-1:0]             ram_addr,
  output logic                                 ram_write_en,
  output logic [DATA_WIDTH*RAMS_TO_ACCESS-1:0] ram_data_in,
  input  logic [DATA_WIDTH*RAMS_TO_ACCESS-1:0] ram_data_out,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH*RAMS_TO_ACCESS-1:0] m_data,
  output logic [RAMS_TO_ACCESS-1:0]            m_lanes,
  output logic                                 m_last
);
  localparam int R      = RAMS_TO_ACCESS;
  localparam int BEAT_W = DATA_WIDTH * R;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = CNT_W + 2;
  localparam int REM_W  = ADDRESS_WIDTH + 1;
  localparam int CHK_W  = ADDRESS_WIDTH + 2;
  localparam logic [CHK_W-1:0]         DEPTH_C     = CHK_W'(DEPTH);
  localparam logic [REM_W-1:0]         R_REM_C     = REM_W'(R);
  localparam logic [ADDRESS_WIDTH-1:0] R_ADDR_C    = ADDRESS_WIDTH'(R);
  localparam logic [OCC_W-1:0]         OCC_LIMIT_C = OCC_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [R-1:0] lane_mask(input logic [REM_W-1:0] rem);
    logic [R-1:0] mask;
    mask = '0;
    for (int i = 0; i < R; i++) begin
      mask[i] = (rem > REM_W'(i));
    end
    return mask;
  endfunction

  function automatic logic [BEAT_W-1:0] mask_beat(input logic [BEAT_W-1:0] beat,
                                                  input logic [R-1:0]      lanes);
    logic [BEAT_W-1:0] res;
    res = '0;
    for (int i = 0; i < R; i++) begin
      res[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i] ? beat[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    return res;
  endfunction

  state_t                   state_r, state_nx_s;
  logic [ADDRESS_WIDTH-1:0] cur_addr_r, ram_addr_r, issue_addr_s;
  logic [REM_W-1:0]         remaining_r, issue_rem_s, take_s, rem_after_s;
  logic                     busy_r, done_r, err_r;
  logic                     issue_s, accept_s, done_set_s, err_set_s, finish_s, range_bad_s;
  logic [R-1:0]             mask_s;
  logic [OCC_W-1:0]         occ_s;
  logic                     pop_s;

  // Each issued read carries its lane mask and last flag through the RAM latency.
  logic                     pend1_r, pend2_r, last1_r, last2_r;
  logic [R-1:0]             lanes1_r, lanes2_r;

  logic [BEAT_W-1:0]        fifo_data_r  [FIFO_DEPTH];
  logic [R-1:0]             fifo_lanes_r [FIFO_DEPTH];
  logic                     fifo_valid_r [FIFO_DEPTH];
  logic                     fifo_last_r  [FIFO_DEPTH];
  logic [BEAT_W-1:0]        fifo_data_nx_s  [FIFO_DEPTH];
  logic [R-1:0]             fifo_lanes_nx_s [FIFO_DEPTH];
  logic                     fifo_valid_nx_s [FIFO_DEPTH];
  logic                     fifo_last_nx_s  [FIFO_DEPTH];
  logic [CNT_W-1:0]         count_r, cnt_pop_s, count_nx_s;
  logic [BEAT_W-1:0]        push_data_s;

  assign pop_s = fifo_valid_r[0] & m_ready;
  assign range_bad_s = ({2'b00, start_addr} >= DEPTH_C) ||
                       (({2'b00, start_addr} + {1'b0, word_count}) > DEPTH_C);

  // Next-state, request screening and read-issue decisions.
  always_comb begin
    state_nx_s   = state_r;
    issue_s      = 1'b0;
    issue_addr_s = cur_addr_r;
    issue_rem_s  = remaining_r;
    accept_s     = 1'b0;
    done_set_s   = 1'b0;
    err_set_s    = 1'b0;
    finish_s     = 1'b0;
    occ_s = OCC_W'(count_r) + OCC_W'(pend1_r) + OCC_W'(pend2_r) - OCC_W'(pop_s);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (range_bad_s) begin
            err_set_s = 1'b1;
          end else if (word_count == '0) begin
            done_set_s = 1'b1;
          end else begin
            accept_s     = 1'b1;
            issue_s      = 1'b1;
            issue_addr_s = start_addr;
            issue_rem_s  = word_count;
            if (word_count <= R_REM_C) begin
              state_nx_s = ST_DRAIN;
            end else begin
              state_nx_s = ST_RUN;
            end
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Occupancy counts reads still in the RAM pipe so the FIFO can never overflow.
        if (occ_s <= OCC_LIMIT_C) begin
          issue_s = 1'b1;
          if (remaining_r <= R_REM_C) begin
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && fifo_last_r[0]) begin
          finish_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    take_s      = (issue_rem_s >= R_REM_C) ? R_REM_C : issue_rem_s;
    rem_after_s = issue_rem_s - take_s;
    mask_s      = lane_mask(issue_rem_s);
  end

  // Control registers, address generator and read-latency tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= '0;
      ram_addr_r  <= '0;
      remaining_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      pend1_r     <= 1'b0;
      pend2_r     <= 1'b0;
      last1_r     <= 1'b0;
      last2_r     <= 1'b0;
      lanes1_r    <= '0;
      lanes2_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= done_set_s | finish_s;
      err_r   <= err_set_s;
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
      if (issue_s) begin
        ram_addr_r  <= issue_addr_s;
        cur_addr_r  <= issue_addr_s + R_ADDR_C;
        remaining_r <= rem_after_s;
      end
      pend1_r  <= issue_s;
      lanes1_r <= issue_s ? mask_s : '0;
      last1_r  <= issue_s & (rem_after_s == '0);
      pend2_r  <= pend1_r;
      lanes2_r <= lanes1_r;
      last2_r  <= last1_r;
    end
  end

  // Shift-style output FIFO: slot 0 is always the head, so m_* come straight from registers.
  always_comb begin
    push_data_s = mask_beat(ram_data_out, lanes2_r);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_data_nx_s[i]  = fifo_data_r[i];
      fifo_lanes_nx_s[i] = fifo_lanes_r[i];
      fifo_valid_nx_s[i] = fifo_valid_r[i];
      fifo_last_nx_s[i]  = fifo_last_r[i];
    end
    if (pop_s) begin
      cnt_pop_s = count_r - CNT_W'(1);
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_data_nx_s[i]  = fifo_data_r[i+1];
        fifo_lanes_nx_s[i] = fifo_lanes_r[i+1];
        fifo_valid_nx_s[i] = fifo_valid_r[i+1];
        fifo_last_nx_s[i]  = fifo_last_r[i+1];
      end
      fifo_data_nx_s[FIFO_DEPTH-1]  = '0;
      fifo_lanes_nx_s[FIFO_DEPTH-1] = '0;
      fifo_valid_nx_s[FIFO_DEPTH-1] = 1'b0;
      fifo_last_nx_s[FIFO_DEPTH-1]  = 1'b0;
    end else begin
      cnt_pop_s = count_r;
    end
    if (pend2_r) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == cnt_pop_s) begin
          fifo_data_nx_s[i]  = push_data_s;
          fifo_lanes_nx_s[i] = lanes2_r;
          fifo_valid_nx_s[i] = 1'b1;
          fifo_last_nx_s[i]  = last2_r;
        end else begin
          fifo_valid_nx_s[i] = fifo_valid_nx_s[i];
        end
      end
    end else begin
      cnt_pop_s = cnt_pop_s;
    end
    count_nx_s = cnt_pop_s + CNT_W'(pend2_r);
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i]  <= '0;
        fifo_lanes_r[i] <= '0;
        fifo_valid_r[i] <= 1'b0;
        fifo_last_r[i]  <= 1'b0;
      end
    end else begin
      count_r <= count_nx_s;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i]  <= fifo_data_nx_s[i];
        fifo_lanes_r[i] <= fifo_lanes_nx_s[i];
        fifo_valid_r[i] <= fifo_valid_nx_s[i];
        fifo_last_r[i]  <= fifo_last_nx_s[i];
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign ram_addr     = ram_addr_r;
  assign ram_write_en = 1'b0;
  assign ram_data_in  = '0;
  assign m_valid      = fifo_valid_r[0];
  assign m_data       = fifo_data_r[0];
  assign m_lanes      = fifo_lanes_r[0];
  assign m_last       = fifo_last_r[0];

endmodule
